// File: rtl/me_scan_controller.sv
// me_scan_controller: integer-pel motion-estimation sequencer. Loads the current-pixel
// register (CPR), then the search-pixel register (SPR), then walks a serpentine full
// search (down, left, up, left, ...) over the search window. A registered candidate
// strobe (valid, mv_x, mv_y) tells the SAD/compare stage that the SPR holds a complete
// candidate. The hold input freezes the sequencer and delays any pending strobe.
// Optional feature: define ME_EARLY_TERM_EN to add the 'term' input (early stop).
module me_scan_controller #(
  parameter int unsigned MACRO_DIM  = 16,
  parameter int unsigned SEARCH_DIM = 48,
  parameter int unsigned ADDR_W     = $clog2(SEARCH_DIM),
  parameter int unsigned MV_W       = $clog2(SEARCH_DIM - MACRO_DIM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
`ifdef ME_EARLY_TERM_EN
  input  logic              term,
`endif
  output logic              ready,
  output logic              en_cpr,
  output logic              en_spr,
  output logic              en_ram,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        sel,
  output logic              valid,
  output logic [MV_W-1:0]   mv_x,
  output logic [MV_W-1:0]   mv_y,
  output logic              done
);

  localparam int unsigned       NOFF       = SEARCH_DIM - MACRO_DIM;
  localparam logic [ADDR_W-1:0] RowMLast   = ADDR_W'(MACRO_DIM - 1);
  localparam logic [ADDR_W-1:0] RowDnFirst = ADDR_W'(MACRO_DIM);
  localparam logic [ADDR_W-1:0] RowLast    = ADDR_W'(SEARCH_DIM - 1);
  localparam logic [ADDR_W-1:0] RowUpFirst = ADDR_W'(NOFF - 1);
  localparam logic [MV_W-1:0]   ColLast    = MV_W'(NOFF);

  typedef enum logic [2:0] {
    StIdle, StLoadCpr, StLoadSpr, StScanDn, StScanUp, StShiftL, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [MV_W-1:0]   c_q, c_d;
  logic              valid_q, valid_d;
  logic [MV_W-1:0]   mv_x_q, mv_x_d, mv_y_q, mv_y_d;
  logic              cpr_act, spr_act, ram_act, done_act;
  logic              cand;
  logic [MV_W-1:0]   cand_x, cand_y;
  logic [ADDR_W-1:0] dn_y;
  logic              early_term;

`ifdef ME_EARLY_TERM_EN
  assign early_term = term;
`else
  assign early_term = 1'b0;
`endif

  // While scanning down, row r completes the candidate whose top row is r-MACRO_DIM+1.
  assign dn_y = r_q - RowDnFirst + ADDR_W'(1);

  // Next-state, counter and candidate decode; hold freezes everything except IDLE.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    ready    = 1'b0;
    cpr_act  = 1'b0;
    spr_act  = 1'b0;
    ram_act  = 1'b0;
    done_act = 1'b0;
    sel      = 2'd0;
    cand     = 1'b0;
    cand_x   = c_q;
    cand_y   = mv_y_q;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          state_d = StLoadCpr;
          r_d     = '0;
          c_d     = '0;
        end
      end
      StLoadCpr: begin
        cpr_act = 1'b1;
        ram_act = 1'b1;
        sel     = 2'd1;
        if (r_q == RowMLast) begin
          state_d = StLoadSpr;
          r_d     = '0;
        end else begin
          r_d = r_q + ADDR_W'(1);
        end
      end
      StLoadSpr: begin
        spr_act = 1'b1;
        ram_act = 1'b1;
        sel     = 2'd1;
        if (r_q == RowMLast) begin
          state_d = StScanDn;
          r_d     = RowDnFirst;
          cand    = 1'b1;
          cand_x  = '0;
          cand_y  = '0;
        end else begin
          r_d = r_q + ADDR_W'(1);
        end
      end
      StScanDn: begin
        spr_act = 1'b1;
        ram_act = 1'b1;
        sel     = 2'd1;
        cand    = 1'b1;
        cand_y  = dn_y[MV_W-1:0];
        if (r_q == RowLast) begin
          state_d = (c_q == ColLast) ? StDone : StShiftL;
        end else begin
          r_d = r_q + ADDR_W'(1);
        end
      end
      StScanUp: begin
        spr_act = 1'b1;
        ram_act = 1'b1;
        sel     = 2'd0;
        cand    = 1'b1;
        cand_y  = r_q[MV_W-1:0];
        if (r_q == '0) begin
          state_d = (c_q == ColLast) ? StDone : StShiftL;
        end else begin
          r_d = r_q - ADDR_W'(1);
        end
      end
      StShiftL: begin
        spr_act = 1'b1;
        sel     = 2'd2;
        cand    = 1'b1;
        cand_x  = c_q + MV_W'(1);
        c_d     = c_q + MV_W'(1);
        // Current column even -> next column odd -> scan upwards.
        if (!c_q[0]) begin
          state_d = StScanUp;
          r_d     = RowUpFirst;
        end else begin
          state_d = StScanDn;
          r_d     = RowDnFirst;
        end
      end
      StDone: begin
        done_act = 1'b1;
        state_d  = StIdle;
        r_d      = '0;
        c_d      = '0;
      end
      default: state_d = StIdle;
    endcase

    // Early stop still lets this cycle's row update (and its candidate) complete.
    if (early_term && (state_q inside {StScanDn, StScanUp, StShiftL})) begin
      state_d = StDone;
    end

    if (hold && (state_q != StIdle)) begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
    end

    // A pending strobe survives hold and is presented once hold falls.
    if (hold) begin
      valid_d = valid_q;
      mv_x_d  = mv_x_q;
      mv_y_d  = mv_y_q;
    end else begin
      valid_d = cand;
      mv_x_d  = cand ? cand_x : mv_x_q;
      mv_y_d  = cand ? cand_y : mv_y_q;
    end
  end

  // State, counters and the registered candidate strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      mv_x_q  <= '0;
      mv_y_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      mv_x_q  <= mv_x_d;
      mv_y_q  <= mv_y_d;
    end
  end

  assign en_cpr = cpr_act & ~hold;
  assign en_spr = spr_act & ~hold;
  assign en_ram = ram_act & ~hold;
  assign done   = done_act & ~hold;
  assign valid  = valid_q & ~hold;
  assign addr   = r_q;
  assign mv_x   = mv_x_q;
  assign mv_y   = mv_y_q;

endmodule

// File: tb/tb_me_scan_controller.sv
// Bench for me_scan_controller: two instances (M=4,S=8 and default M=16,S=48). Expected
// per-cycle vectors are generated from the serpentine search rules, with optional random
// hold cycles and stray start pulses, then applied and compared cycle by cycle.
module tb_me_scan_controller;

  typedef struct {
    bit start;
    bit hold;
    bit ready;
    bit en_cpr;
    bit en_spr;
    bit en_ram;
    bit valid;
    bit done;
    bit chk_addr;
    int sel;
    int addr;
    int mv_x;
    int mv_y;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  int   cur = 0;
  logic start_s, start_b;

  logic       s_ready, s_en_cpr, s_en_spr, s_en_ram, s_valid, s_done;
  logic [2:0] s_addr, s_mv_x, s_mv_y;
  logic [1:0] s_sel;
  logic       b_ready, b_en_cpr, b_en_spr, b_en_ram, b_valid, b_done;
  logic [5:0] b_addr, b_mv_x, b_mv_y;
  logic [1:0] b_sel;

  logic       o_ready, o_en_cpr, o_en_spr, o_en_ram, o_valid, o_done;
  logic [7:0] o_addr, o_mv_x, o_mv_y;
  logic [1:0] o_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign start_s = start & (cur == 0);
  assign start_b = start & (cur == 1);

  me_scan_controller #(.MACRO_DIM(4), .SEARCH_DIM(8)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .hold(hold),
`ifdef ME_EARLY_TERM_EN
    .term(1'b0),
`endif
    .ready(s_ready), .en_cpr(s_en_cpr), .en_spr(s_en_spr), .en_ram(s_en_ram),
    .addr(s_addr), .sel(s_sel), .valid(s_valid), .mv_x(s_mv_x), .mv_y(s_mv_y),
    .done(s_done)
  );

  me_scan_controller u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold),
`ifdef ME_EARLY_TERM_EN
    .term(1'b0),
`endif
    .ready(b_ready), .en_cpr(b_en_cpr), .en_spr(b_en_spr), .en_ram(b_en_ram),
    .addr(b_addr), .sel(b_sel), .valid(b_valid), .mv_x(b_mv_x), .mv_y(b_mv_y),
    .done(b_done)
  );

  assign o_ready  = (cur == 0) ? s_ready  : b_ready;
  assign o_en_cpr = (cur == 0) ? s_en_cpr : b_en_cpr;
  assign o_en_spr = (cur == 0) ? s_en_spr : b_en_spr;
  assign o_en_ram = (cur == 0) ? s_en_ram : b_en_ram;
  assign o_valid  = (cur == 0) ? s_valid  : b_valid;
  assign o_done   = (cur == 0) ? s_done   : b_done;
  assign o_sel    = (cur == 0) ? s_sel    : b_sel;
  assign o_addr   = (cur == 0) ? {5'd0, s_addr} : {2'd0, b_addr};
  assign o_mv_x   = (cur == 0) ? {5'd0, s_mv_x} : {2'd0, b_mv_x};
  assign o_mv_y   = (cur == 0) ? {5'd0, s_mv_y} : {2'd0, b_mv_y};

  vec_t vecs[$];
  bit   m_pv;
  int   m_px, m_py;
  int   m_hold_pct;
  bit   m_noise;
  int   m_up_row;
  bit   m_up_done;
  bit   seen [0:255][0:255];

  // Packed layout: {ready, en_cpr, en_spr, en_ram, valid, done, sel[1:0], addr, mv_x, mv_y}
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.start = 0; v.hold = 0; v.ready = 0; v.en_cpr = 0; v.en_spr = 0; v.en_ram = 0;
    v.valid = 0; v.done = 0; v.chk_addr = 0; v.sel = 0; v.addr = 0; v.mv_x = 0; v.mv_y = 0;
    return v;
  endfunction

  function automatic bit rnd_start();
    return m_noise && ($urandom_range(0, 3) == 0);
  endfunction

  // One sequencer step, preceded by any hold cycles; its strobe shows the previous candidate.
  task automatic exec(input bit c, input bit sp, input bit ram, input int a, input int sl,
                      input bit dn, input bit cand, input int cx, input int cy);
    vec_t v;
    int   nh;
    nh = 0;
    if (m_hold_pct > 0 && $urandom_range(0, 99) < m_hold_pct) nh = $urandom_range(1, 3);
    if (m_up_row >= 0 && ram && sl == 0 && a == m_up_row && !m_up_done) begin
      nh = 5;
      m_up_done = 1;
    end
    for (int h = 0; h < nh; h++) begin
      v = blank();
      v.hold = 1; v.start = rnd_start(); v.chk_addr = ram; v.addr = a;
      vecs.push_back(v);
    end
    v = blank();
    v.start = rnd_start(); v.en_cpr = c; v.en_spr = sp; v.en_ram = ram; v.sel = sl;
    v.chk_addr = ram; v.addr = a; v.valid = m_pv; v.mv_x = m_px; v.mv_y = m_py; v.done = dn;
    vecs.push_back(v);
    m_pv = cand; m_px = cx; m_py = cy;
  endtask

  task automatic build(input int m, input int s, input int hold_pct, input bit noise,
                       input int up_row, input bit idle_hold);
    int   noff;
    int   ylast;
    vec_t v;
    noff = s - m;
    vecs.delete();
    m_pv = 0; m_px = 0; m_py = 0;
    m_hold_pct = hold_pct; m_noise = noise; m_up_row = up_row; m_up_done = 0;
    v = blank(); v.start = 1; v.hold = idle_hold; v.ready = 1;
    vecs.push_back(v);
    for (int r = 0; r < m; r++) exec(1, 0, 1, r, 1, 0, 0, 0, 0);
    for (int r = 0; r < m; r++) exec(0, 1, 1, r, 1, 0, r == m - 1, 0, 0);
    ylast = 0;
    for (int x = 0; x <= noff; x++) begin
      if (x > 0) exec(0, 1, 0, 0, 2, 0, 1, x, ylast);
      if (x % 2 == 0) begin
        for (int y = 1; y <= noff; y++) exec(0, 1, 1, y + m - 1, 1, 0, 1, x, y);
        ylast = noff;
      end else begin
        for (int y = noff - 1; y >= 0; y--) exec(0, 1, 1, y, 0, 0, 1, x, y);
        ylast = 0;
      end
    end
    exec(0, 0, 0, 0, 0, 1, 0, 0, 0);
    v = blank(); v.ready = 1; v.valid = m_pv;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] pack_exp(input vec_t v);
    logic [1:0] sl;
    logic [7:0] a, x, y;
    sl = v.en_spr ? 2'(v.sel) : 2'd0;
    a  = v.chk_addr ? 8'(v.addr) : 8'd0;
    x  = v.valid ? 8'(v.mv_x) : 8'd0;
    y  = v.valid ? 8'(v.mv_y) : 8'd0;
    return {v.ready, v.en_cpr, v.en_spr, v.en_ram, v.valid, v.done, sl, a, x, y};
  endfunction

  function automatic logic [31:0] pack_act(input vec_t v);
    logic [1:0] sl;
    logic [7:0] a, x, y;
    sl = v.en_spr ? o_sel : 2'd0;
    a  = v.chk_addr ? o_addr : 8'd0;
    x  = v.valid ? o_mv_x : 8'd0;
    y  = v.valid ? o_mv_y : 8'd0;
    return {o_ready, o_en_cpr, o_en_spr, o_en_ram, o_valid, o_done, sl, a, x, y};
  endfunction

  task automatic check_idle(input string name, input bit full);
    logic [31:0] act;
    act = {o_ready, o_en_cpr, o_en_spr, o_en_ram, o_valid, o_done, o_sel,
           full ? o_addr : 8'd0, full ? o_mv_x : 8'd0, full ? o_mv_y : 8'd0};
    cmp(name, act, {1'b1, 31'd0});
  endtask

  task automatic apply(input string tag, input int m, input int s, input int abort_at,
                       input bit chk_lat);
    int  noff, strobes, dups, dones, done_cyc;
    bit  aborted;
    noff = s - m;
    strobes = 0; dups = 0; dones = 0; done_cyc = -1; aborted = 0;
    for (int i = 0; i < 256; i++) for (int j = 0; j < 256; j++) seen[i][j] = 0;
    for (int i = 0; i < vecs.size() && !aborted; i++) begin
      @(negedge clk);
      start = vecs[i].start;
      hold  = vecs[i].hold;
      if (i == abort_at) begin
        aborted = 1;
        start = 0; hold = 0; rst_n = 0;
        #1;
        check_idle($sformatf("%s reset_mid", tag), 1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); #1;
          check_idle($sformatf("%s in_reset%0d", tag, k), 1);
        end
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); #1;
          check_idle($sformatf("%s post_reset%0d", tag, k), 1);
        end
      end else begin
        #1;
        cmp($sformatf("%s cyc%0d", tag, i), pack_act(vecs[i]), pack_exp(vecs[i]));
        if (o_valid === 1'b1) begin
          strobes++;
          if (seen[o_mv_x][o_mv_y]) dups++;
          seen[o_mv_x][o_mv_y] = 1;
        end
        if (o_done === 1'b1) begin
          dones++;
          if (done_cyc < 0) done_cyc = i;
        end
      end
    end
    start = 0;
    hold  = 0;
    if (!aborted) begin
      cmp($sformatf("%s strobes", tag), 32'(strobes), 32'((noff + 1) * (noff + 1)));
      cmp($sformatf("%s dup_strobes", tag), 32'(dups), 32'd0);
      cmp($sformatf("%s done_pulses", tag), 32'(dones), 32'd1);
      if (chk_lat)
        cmp($sformatf("%s done_cycle", tag), 32'(done_cyc),
            32'(2 * m + noff * (noff + 1) + noff + 1));
    end
  endtask

  initial begin
    rst_n = 0;
    cur   = 0;
    @(negedge clk); #1;
    check_idle("reset_small", 1);
    cur = 1; #1;
    check_idle("reset_big", 1);
    @(negedge clk);
    rst_n = 1;
    hold  = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check_idle($sformatf("idle_hold%0d", k), 1);
    end
    hold = 0;

    cur = 0;
    build(4, 8, 0, 0, -1, 0);
    apply("m4_plain", 4, 8, -1, 1);
    for (int k = 0; k < 3; k++) begin
      build(4, 8, 25, 1, -1, k == 0);
      apply($sformatf("m4_rand%0d", k), 4, 8, -1, 0);
    end

    cur = 1;
    build(16, 48, 0, 0, -1, 0);
    apply("m16_plain", 16, 48, -1, 1);
    build(16, 48, 0, 1, 10, 1);
    apply("m16_hold_up10", 16, 48, -1, 0);
    build(16, 48, 8, 1, -1, 0);
    apply("m16_rand", 16, 48, -1, 0);
    build(16, 48, 0, 0, -1, 0);
    apply("m16_abort", 16, 48, 500, 0);

    cur = 0;
    build(4, 8, 0, 0, -1, 0);
    apply("m4_after_reset", 4, 8, -1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
